// File: rtl/pulse_timer_ctrl.sv
// Programmable period/phase pulse time base with start/stop, one-shot and periodic runs.
// New configs are held in a shadow and only take effect on a period boundary or while idle.
module pulse_timer_ctrl #(
    parameter int          CNT_W          = 24,
    parameter int unsigned DEFAULT_PERIOD = 5000000,
    parameter int unsigned DEFAULT_PHASE  = 3000000
) (
    input  logic             Origin_Clock,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_phase,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       state_dbg
);

    // Config handshake: a config transfers on any rising edge where cfg_valid && cfg_ready.
    // cfg_ready stays low while a captured config waits in the shadow for its apply point.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] DEF_PHASE  = CNT_W'(DEFAULT_PHASE);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] phase_r;
    logic             oneshot_r;
    logic [CNT_W-1:0] shadow_period;
    logic [CNT_W-1:0] shadow_phase;
    logic             shadow_oneshot;
    logic             pending;

    logic [CNT_W-1:0] san_period;
    logic [CNT_W-1:0] san_phase;
    logic             capture;
    logic             at_last;
    logic             direct_apply;
    logic             apply_now;

    always_comb begin
        san_period   = (cfg_period == '0) ? ONE : cfg_period;
        san_phase    = (cfg_phase >= san_period) ? (san_period - ONE) : cfg_phase;
        capture      = cfg_valid && !pending;
        at_last      = (count == (period_r - ONE));
        // A config captured together with a start from IDLE goes straight into the run.
        direct_apply = capture && (state == IDLE) && start && !stop;
        apply_now    = pending && ((state != RUN) || stop || at_last);
    end

    assign cfg_ready = !pending;
    assign pulse     = (state == RUN) && (count == phase_r);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign state_dbg = state;

    always_ff @(posedge Origin_Clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            count          <= '0;
            period_r       <= DEF_PERIOD;
            phase_r        <= DEF_PHASE;
            oneshot_r      <= 1'b0;
            shadow_period  <= '0;
            shadow_phase   <= '0;
            shadow_oneshot <= 1'b0;
            pending        <= 1'b0;
        end else begin
            if (apply_now) begin
                period_r  <= shadow_period;
                phase_r   <= shadow_phase;
                oneshot_r <= shadow_oneshot;
                pending   <= 1'b0;
            end else if (direct_apply) begin
                period_r  <= san_period;
                phase_r   <= san_phase;
                oneshot_r <= cfg_oneshot;
            end else if (capture) begin
                shadow_period  <= san_period;
                shadow_phase   <= san_phase;
                shadow_oneshot <= cfg_oneshot;
                pending        <= 1'b1;
            end

            case (state)
                IDLE: begin
                    count <= '0;
                    if (start && !stop) state <= RUN;
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (at_last) begin
                        count <= '0;
                        state <= oneshot_r ? DONE : RUN;
                    end else begin
                        count <= count + ONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    count <= '0;
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_timer_ctrl.sv
// Bench for pulse_timer_ctrl: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a rule-level model of the timer.
module tb_pulse_timer_ctrl;

    localparam int W     = 16;
    localparam int DEF_P = 40;
    localparam int DEF_PH = 25;

    logic         clk;
    logic         reset;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cfg_phase;
    logic         cfg_oneshot;
    logic         start;
    logic         stop;
    logic         pulse;
    logic         busy;
    logic         done;
    logic [W-1:0] count;
    logic [1:0]   state_dbg;

    int n_total = 0;
    int n_pass  = 0;
    bit run_cmp = 0;

    pulse_timer_ctrl #(
        .CNT_W(W),
        .DEFAULT_PERIOD(DEF_P),
        .DEFAULT_PHASE(DEF_PH)
    ) dut (
        .Origin_Clock(clk),
        .reset(reset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_period(cfg_period),
        .cfg_phase(cfg_phase),
        .cfg_oneshot(cfg_oneshot),
        .start(start),
        .stop(stop),
        .pulse(pulse),
        .busy(busy),
        .done(done),
        .count(count),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endfunction

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 running, 2 one-shot just finished
    int m_mode, m_cnt, m_per, m_ph, m_os, m_pend, s_per, s_ph, s_os;

    always @(posedge clk or negedge reset) begin
        int nmode, ncnt, nper, nph, nos, npend, nsper, nsph, nsos, cp, cph;
        bit cap, take_shadow;
        if (!reset) begin
            m_mode <= 0; m_cnt <= 0; m_per <= DEF_P; m_ph <= DEF_PH;
            m_os <= 0; m_pend <= 0; s_per <= 0; s_ph <= 0; s_os <= 0;
        end else begin
            nmode = m_mode; ncnt = m_cnt; nper = m_per; nph = m_ph; nos = m_os;
            npend = m_pend; nsper = s_per; nsph = s_ph; nsos = s_os;
            cp  = (int'(cfg_period) == 0) ? 1 : int'(cfg_period);
            cph = (int'(cfg_phase) >= cp) ? cp - 1 : int'(cfg_phase);
            cap = cfg_valid && (m_pend == 0);
            take_shadow = 0;
            if (m_mode == 1) begin
                if (stop) begin
                    nmode = 0; ncnt = 0; take_shadow = 1;
                end else if (m_cnt == m_per - 1) begin
                    ncnt = 0; nmode = m_os ? 2 : 1; take_shadow = 1;
                end else begin
                    ncnt = m_cnt + 1;
                end
            end else begin
                ncnt = 0;
                take_shadow = 1;
                if (m_mode == 2) nmode = 0;
                else if (start && !stop) begin
                    nmode = 1;
                    if (cap) begin
                        nper = cp; nph = cph; nos = int'(cfg_oneshot); cap = 0;
                    end
                end
            end
            if (take_shadow && m_pend != 0) begin
                nper = s_per; nph = s_ph; nos = s_os; npend = 0;
            end
            if (cap) begin
                nsper = cp; nsph = cph; nsos = int'(cfg_oneshot); npend = 1;
            end
            m_mode <= nmode; m_cnt <= ncnt; m_per <= nper; m_ph <= nph; m_os <= nos;
            m_pend <= npend; s_per <= nsper; s_ph <= nsph; s_os <= nsos;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("m_count", int'(count), m_cnt);
            chk("m_pulse", int'(pulse), int'(m_mode == 1 && m_cnt == m_ph));
            chk("m_busy",  int'(busy),  int'(m_mode == 1));
            chk("m_done",  int'(done),  int'(m_mode == 2));
            chk("m_ready", int'(cfg_ready), int'(m_pend == 0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer_cfg(input int p, input int ph, input bit os);
        cfg_valid   = 1'b1;
        cfg_period  = W'(p);
        cfg_phase   = W'(ph);
        cfg_oneshot = os;
    endtask

    task automatic send_cfg(input int p, input int ph, input bit os);
        offer_cfg(p, ph, os);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_phase = '0;
        cfg_oneshot = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_count", int'(count), 0);
        reset = 1'b1;
        run_cmp = 1'b1;
        tick();

        // periodic 5/3
        send_cfg(5, 3, 0);
        chk("t1_ready_low", int'(cfg_ready), 0);
        tick();
        chk("t1_ready_back", int'(cfg_ready), 1);
        do_start();
        chk("t1_busy", int'(busy), 1);
        chk("t1_count0", int'(count), 0);
        repeat (3) tick();
        chk("t1_pulse_c3", int'(pulse), 1);
        tick();
        chk("t1_no_pulse_c4", int'(pulse), 0);
        repeat (4) tick();
        chk("t1_count_again3", int'(count), 3);
        chk("t1_pulse_again", int'(pulse), 1);
        chk("t1_no_done", int'(done), 0);
        do_stop();
        chk("t1_stop_busy", int'(busy), 0);

        // one-shot 4/1
        offer_cfg(4, 1, 1);
        tick();
        cfg_valid = 1'b0;
        do_start();
        chk("t2_busy", int'(busy), 1);
        tick();
        chk("t2_pulse_c1", int'(pulse), 1);
        repeat (2) tick();
        chk("t2_count3", int'(count), 3);
        tick();
        chk("t2_done", int'(done), 1);
        chk("t2_busy_low", int'(busy), 0);
        tick();
        chk("t2_done_clear", int'(done), 0);
        chk("t2_count_idle", int'(count), 0);

        // retune mid-run: 6/2 -> 3/0
        send_cfg(6, 2, 0);
        tick();
        do_start();
        tick();
        offer_cfg(3, 0, 0);
        tick();
        cfg_valid = 1'b0;
        chk("t3_pulse_c2", int'(pulse), 1);
        chk("t3_ready_low", int'(cfg_ready), 0);
        repeat (3) tick();
        chk("t3_count5", int'(count), 5);
        chk("t3_still_pending", int'(cfg_ready), 0);
        tick();
        chk("t3_wrap_pulse", int'(pulse), 1);
        chk("t3_ready_back", int'(cfg_ready), 1);
        repeat (3) tick();
        chk("t3_period3_pulse", int'(pulse), 1);
        tick();
        chk("t3_count1", int'(count), 1);
        do_stop();

        // sanitising
        offer_cfg(0, 7, 0);
        start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        chk("t4_p1_pulse", int'(pulse), 1);
        chk("t4_p1_ready", int'(cfg_ready), 1);
        tick();
        chk("t4_p1_pulse2", int'(pulse), 1);
        chk("t4_p1_count", int'(count), 0);
        do_stop();
        send_cfg(4, 9, 0);
        tick();
        do_start();
        repeat (3) tick();
        chk("t4_phase3_pulse", int'(pulse), 1);
        do_stop();

        // stop/start collision and stop mid-run
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("t5_collide_idle", int'(busy), 0);
        send_cfg(5, 4, 0);
        tick();
        do_start();
        repeat (2) tick();
        stop = 1'b1;
        #1;
        chk("t5_no_pulse", int'(pulse), 0);
        tick();
        stop = 1'b0;
        chk("t5_stop_idle", int'(busy), 0);
        chk("t5_stop_count", int'(count), 0);

        // async reset mid-run with a pending config, then default period
        send_cfg(5, 3, 0);
        tick();
        do_start();
        repeat (2) tick();
        send_cfg(7, 1, 0);
        chk("t6_pending", int'(cfg_ready), 0);
        #2 reset = 1'b0;
        #1;
        chk("t6_busy", int'(busy), 0);
        chk("t6_ready", int'(cfg_ready), 1);
        chk("t6_count", int'(count), 0);
        chk("t6_pulse", int'(pulse), 0);
        chk("t6_done", int'(done), 0);
        @(posedge clk);
        #2 reset = 1'b1;
        tick();
        do_start();
        repeat (DEF_PH) tick();
        chk("t6_def_pulse", int'(pulse), 1);
        repeat (DEF_P - 1 - DEF_PH) tick();
        chk("t6_def_last", int'(count), DEF_P - 1);
        tick();
        chk("t6_def_wrap", int'(count), 0);
        do_stop();

        // randomized stimulus
        for (int i = 0; i < 3000; i++) begin
            cfg_valid   = ($urandom_range(0, 5) == 0);
            cfg_period  = W'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 8));
            cfg_phase   = W'($urandom_range(0, 12));
            cfg_oneshot = $urandom_range(0, 1);
            start       = ($urandom_range(0, 3) == 0);
            stop        = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #2 reset = 1'b0;
                tick();
                #2 reset = 1'b1;
            end
            tick();
        end
        cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
        tick();
        run_cmp = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
